// File: rtl/modport_adder_pkg.sv
// Shared types and defaults for the registered adder and its driver/dut interface.
package modport_adder_pkg;
    localparam int DEFAULT_WIDTH = 4;

    typedef logic [DEFAULT_WIDTH-1:0] operand_t;
    typedef logic [DEFAULT_WIDTH:0]   sum_t;
endpackage

// File: rtl/add_if.sv
// Bundle of operand/sum handshake signals with driver-side and adder-side views.
interface add_if
    import modport_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   c;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;

    modport drv (
        output a, b, in_valid, out_ready,
        input  c, in_ready, out_valid
    );

    modport dut (
        input  a, b, in_valid, out_ready,
        output c, in_ready, out_valid
    );
endinterface

// File: rtl/sum_core.sv
// Combinational zero-extended sum; the carry lands in the extra MSB.
module sum_core
    import modport_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);
    assign o_sum = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/modport_adder.sv
// Registered unsigned adder with valid/ready on both sides and a one-entry skid
// so a sum can be accepted every clock even when the consumer stalls.
module modport_adder
    import modport_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   c,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH:0] w_sum;
    logic           w_accept;
    logic           w_out_free;

    logic [WIDTH:0] r_c;
    logic           r_out_valid;
    logic [WIDTH:0] r_skid;
    logic           r_skid_full;

    sum_core #(.WIDTH(WIDTH)) u_sum_core (
        .i_a   (a),
        .i_b   (b),
        .o_sum (w_sum)
    );

    assign in_ready   = !r_skid_full;
    assign w_accept   = in_valid && !r_skid_full;
    // Output register can take a new value if empty or being drained this edge.
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c         <= '0;
            r_out_valid <= 1'b0;
            r_skid      <= '0;
            r_skid_full <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_full) begin
                r_c         <= r_skid;
                r_out_valid <= 1'b1;
                r_skid_full <= 1'b0;
            end else if (w_accept) begin
                r_c         <= w_sum;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Output is held by a stalled consumer: park the new sum.
            r_skid      <= w_sum;
            r_skid_full <= 1'b1;
        end
    end

    assign c         = r_c;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_modport_adder.sv
// Bench for modport_adder: directed vector table, reset-mid-stall sequence,
// and randomized traffic against a two-deep FIFO reference model.
module tb_modport_adder;
    import modport_adder_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst_n;

    add_if #(.WIDTH(W)) bus ();

    modport_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (bus.a),
        .b         (bus.b),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .c         (bus.c),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: the block behaves as a FIFO of at most two sums;
    // head of the queue is what c must show while out_valid is high.
    int q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         iv;
        logic         ordy;
        logic [W:0]   ec;
        logic         eov;
        logic         eir;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic iv, input logic ordy);
        bit acc;
        bit xf;
        bus.a         = ia;
        bus.b         = ib;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        acc = iv && (q.size() < 2);
        xf  = (q.size() > 0) && ordy;
        @(posedge clk);
        if (xf)  void'(q.pop_front());
        if (acc) q.push_back(int'(ia) + int'(ib));
        #1;
        chk("model_in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("model_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("model_c", 32'(bus.c), 32'(q[0]));
    endtask

    initial begin
        // Directed rows: inputs applied for one clock, expectations after that edge.
        tbl[0]  = '{4'd6,  4'd4,  1'b1, 1'b1, 5'd10, 1'b1, 1'b1};
        tbl[1]  = '{4'd15, 4'd15, 1'b1, 1'b1, 5'd30, 1'b1, 1'b1};
        tbl[2]  = '{4'd0,  4'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b1};
        tbl[3]  = '{4'bx,  4'bx,  1'b0, 1'b1, 5'd0,  1'b0, 1'b1};
        tbl[4]  = '{4'd1,  4'd1,  1'b1, 1'b1, 5'd2,  1'b1, 1'b1};
        tbl[5]  = '{4'd2,  4'd2,  1'b1, 1'b1, 5'd4,  1'b1, 1'b1};
        tbl[6]  = '{4'd3,  4'd3,  1'b1, 1'b1, 5'd6,  1'b1, 1'b1};
        tbl[7]  = '{4'bx,  4'bx,  1'b0, 1'b1, 5'd0,  1'b0, 1'b1};
        tbl[8]  = '{4'd5,  4'd5,  1'b1, 1'b0, 5'd10, 1'b1, 1'b1};
        tbl[9]  = '{4'd7,  4'd1,  1'b1, 1'b0, 5'd10, 1'b1, 1'b0};
        tbl[10] = '{4'd9,  4'd9,  1'b1, 1'b0, 5'd10, 1'b1, 1'b0};
        tbl[11] = '{4'd9,  4'd9,  1'b1, 1'b0, 5'd10, 1'b1, 1'b0};
        tbl[12] = '{4'bx,  4'bx,  1'b0, 1'b1, 5'd8,  1'b1, 1'b1};
        tbl[13] = '{4'bx,  4'bx,  1'b0, 1'b1, 5'd0,  1'b0, 1'b1};
        tbl[14] = '{4'd12, 4'd9,  1'b1, 1'b0, 5'd21, 1'b1, 1'b1};

        rst_n         = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("reset_c", 32'(bus.c), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 15; i++) begin
            drive_cycle(tbl[i].a, tbl[i].b, tbl[i].iv, tbl[i].ordy);
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].eov));
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].eir));
            if (tbl[i].eov) chk($sformatf("vec%0d_c", i), 32'(bus.c), 32'(tbl[i].ec));
        end

        // Stall again to fill the skid, then reset asynchronously between edges.
        drive_cycle(4'd5, 4'd5, 1'b1, 1'b0);
        chk("stall_full_in_ready", 32'(bus.in_ready), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_c", 32'(bus.c), 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        q.delete();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(4'bx, 4'bx, 1'b0, 1'b1);
        chk("skid_lost_out_valid", 32'(bus.out_valid), 32'd0);
        drive_cycle(4'd3, 4'd4, 1'b1, 1'b1);
        chk("post_rst_c", 32'(bus.c), 32'd7);

        for (int i = 0; i < 400; i++) begin
            drive_cycle(W'($urandom), W'($urandom),
                        1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
